// File: rtl/si_header_parser_gen.sv
// SI/TT header parser: buffers and validates the 28-byte header, replays it, then passes the payload through.
// Define SI_HEADER_PARSER_STATS_EN to build the cnt_valid/cnt_dropped/cnt_lost statistics counters.
module si_header_parser_gen #(
    parameter int         DATA_WIDTH       = 128,
    parameter logic [7:0] EXPECTED_VERSION = 8'h00,
    parameter logic [7:0] EXPECTED_TYPE    = 8'h00,
    parameter int         CNT_WIDTH        = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    lost_packet,
    output logic [31:0]             lost_count,
    output logic                    invalid_packet,
    output logic [CNT_WIDTH-1:0]    cnt_valid,
    output logic [CNT_WIDTH-1:0]    cnt_dropped,
    output logic [CNT_WIDTH-1:0]    cnt_lost
);

    localparam int         KW        = DATA_WIDTH / 8;
    localparam int         HDR_BEATS = (28 + KW - 1) / KW;
    localparam int         HDR_BITS  = HDR_BEATS * DATA_WIDTH;
    localparam logic [1:0] LAST_BEAT = 2'(HDR_BEATS - 1);

    generate
        if (DATA_WIDTH != 64 && DATA_WIDTH != 128 && DATA_WIDTH != 256) begin : g_bad_width
            $error("si_header_parser_gen: DATA_WIDTH must be 64, 128 or 256");
        end
        if (CNT_WIDTH < 8 || CNT_WIDTH > 64) begin : g_bad_cnt_width
            $error("si_header_parser_gen: CNT_WIDTH must be within 8..64");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CHECK,
        S_REPLAY,
        S_PASS,
        S_DROP,
        S_DROP_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            beat_q, beat_d;
    logic [HDR_BITS-1:0]   hdr_q, hdr_d;
    logic                  keep_ok_q, keep_ok_d;
    logic [31:0]           next_seq_q, next_seq_d;
    logic                  lost_packet_q, lost_packet_d;
    logic [31:0]           lost_count_q, lost_count_d;

    logic                  s_ready;
    logic                  hdr_ok;
    logic [31:0]           seq;
    logic [31:0]           gap_count;
    logic                  seq_gap;
    logic [DATA_WIDTH-1:0] replay_data;

    assign seq       = hdr_q[24*8 +: 32];
    assign gap_count = seq - next_seq_q;
    assign seq_gap   = (seq != next_seq_q) && (next_seq_q != 32'd0);
    assign hdr_ok    = keep_ok_q
                    && hdr_q[12*8 +: 8] == 8'h80 && hdr_q[13*8 +: 8] == 8'h9B
                    && hdr_q[14*8 +: 8] == 8'h53 && hdr_q[15*8 +: 8] == 8'h49
                    && hdr_q[16*8 +: 8] == 8'h54 && hdr_q[17*8 +: 8] == 8'h54
                    && hdr_q[18*8 +: 8] == EXPECTED_VERSION
                    && hdr_q[19*8 +: 8] == EXPECTED_TYPE;

    // Input ready is forced low for as long as reset is held.
    assign s_axis_tready  = s_ready & rst_n;
    assign lost_packet    = lost_packet_q;
    assign lost_count     = lost_count_q;

    always_comb begin
        replay_data = '0;
        for (int i = 0; i < HDR_BEATS; i++) begin
            if (beat_q == 2'(i)) begin
                replay_data = hdr_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        hdr_d          = hdr_q;
        keep_ok_d      = keep_ok_q;
        next_seq_d     = next_seq_q;
        lost_packet_d  = 1'b0;
        lost_count_d   = lost_count_q;
        s_ready        = 1'b0;
        m_axis_tvalid  = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tkeep   = '0;
        m_axis_tlast   = 1'b0;
        invalid_packet = 1'b0;

        case (state_q)
            S_IDLE: begin
                s_ready = 1'b1;
                beat_d  = 2'd0;
                if (s_axis_tvalid) begin
                    hdr_d[0 +: DATA_WIDTH] = s_axis_tdata;
                    keep_ok_d              = &s_axis_tkeep;
                    if (s_axis_tlast) begin
                        state_d = S_DROP_DONE;
                    end else if (HDR_BEATS > 1) begin
                        state_d = S_HDR;
                        beat_d  = 2'd1;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_HDR: begin
                s_ready = 1'b1;
                if (s_axis_tvalid) begin
                    for (int i = 1; i < HDR_BEATS; i++) begin
                        if (beat_q == 2'(i)) begin
                            hdr_d[i*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
                        end
                    end
                    keep_ok_d = keep_ok_q & (&s_axis_tkeep);
                    // Any tlast inside the header makes the packet a runt.
                    if (s_axis_tlast) begin
                        state_d = S_DROP_DONE;
                        beat_d  = 2'd0;
                    end else if (beat_q == LAST_BEAT) begin
                        state_d = S_CHECK;
                        beat_d  = 2'd0;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            S_CHECK: begin
                if (hdr_ok) begin
                    if (seq_gap) begin
                        lost_packet_d = 1'b1;
                        lost_count_d  = gap_count;
                    end
                    next_seq_d = seq + 32'd1;
                    state_d    = S_REPLAY;
                end else begin
                    state_d = S_DROP;
                end
            end
            S_REPLAY: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = replay_data;
                m_axis_tkeep  = '1;
                if (m_axis_tready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_PASS;
                        beat_d  = 2'd0;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            S_PASS: begin
                s_ready       = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tlast  = s_axis_tlast;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                s_ready        = 1'b1;
                invalid_packet = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = S_IDLE;
                end
            end
            S_DROP_DONE: begin
                invalid_packet = 1'b1;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            beat_q        <= 2'd0;
            hdr_q         <= '0;
            keep_ok_q     <= 1'b0;
            next_seq_q    <= 32'd0;
            lost_packet_q <= 1'b0;
            lost_count_q  <= 32'd0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            hdr_q         <= hdr_d;
            keep_ok_q     <= keep_ok_d;
            next_seq_q    <= next_seq_d;
            lost_packet_q <= lost_packet_d;
            lost_count_q  <= lost_count_d;
        end
    end

`ifdef SI_HEADER_PARSER_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] cnt_valid_q, cnt_valid_d;
    logic [CNT_WIDTH-1:0] cnt_dropped_q, cnt_dropped_d;
    logic [CNT_WIDTH-1:0] cnt_lost_q, cnt_lost_d;
    logic [64:0]          lost_sum;
    logic                 drop_evt;

    assign drop_evt = (state_q == S_CHECK && !hdr_ok) || state_q == S_DROP_DONE;

    // All counters saturate; the lost total is summed wide so the clamp sees any overflow.
    always_comb begin
        cnt_valid_d   = cnt_valid_q;
        cnt_dropped_d = cnt_dropped_q;
        cnt_lost_d    = cnt_lost_q;
        lost_sum      = 65'(cnt_lost_q) + 65'(gap_count);
        if (state_q == S_CHECK && hdr_ok && cnt_valid_q != CNT_MAX) begin
            cnt_valid_d = cnt_valid_q + CNT_WIDTH'(1);
        end
        if (drop_evt && cnt_dropped_q != CNT_MAX) begin
            cnt_dropped_d = cnt_dropped_q + CNT_WIDTH'(1);
        end
        if (lost_packet_d) begin
            cnt_lost_d = (lost_sum > 65'(CNT_MAX)) ? CNT_MAX : lost_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_valid_q   <= '0;
            cnt_dropped_q <= '0;
            cnt_lost_q    <= '0;
        end else begin
            cnt_valid_q   <= cnt_valid_d;
            cnt_dropped_q <= cnt_dropped_d;
            cnt_lost_q    <= cnt_lost_d;
        end
    end

    assign cnt_valid   = cnt_valid_q;
    assign cnt_dropped = cnt_dropped_q;
    assign cnt_lost    = cnt_lost_q;
`else
    assign cnt_valid   = '0;
    assign cnt_dropped = '0;
    assign cnt_lost    = '0;
`endif

endmodule
